onoff_rr_arbiter: RTL
=====================

// Module: onoff_rr_arbiter
// PURPOSE
//  - Shares one ON/OFF resource (single-bit enable FSM: OFF=0, ON=1) among N requesters.
//  - Round-robin grant, optional bounded hold time, one mandatory OFF gap cycle between owners.
//  - Sits in front of the ON/OFF resource; busy drives its enable, owner steers its user mux.
// PARAMETERS
//  - N         4  number of requesters (N >= 2)
//  - MAX_HOLD  8  max consecutive grant cycles per ownership (>= 1; used only with ARB_TIMEOUT_EN)
//  - IDW = $clog2(N) is a localparam, not a parameter.
// PORTS
//  - clk      in   1    single clock, all logic on rising edge
//  - reset    in   1    synchronous, active-high
//  - req      in   N    request per requester, level, held until served
//  - done     in   N    release pulse per requester; only done[owner] is honoured
//  - grant    out  N    one-hot grant, registered
//  - busy     out  1    resource ON (= |grant), registered
//  - owner    out  IDW  index of granted requester; 0 when not busy
//  - expired  out  1    1-cycle pulse: ownership ended by hold timeout
// BEHAVIOUR
//  - Reset (sampled at clk edge): state=IDLE, grant=0, busy=0, owner=0, expired=0,
//    last_owner=N-1 (requester 0 wins first), hold_cnt=0. Reset mid-ON drops grant at that edge.
//  - States: IDLE (OFF), ON (granted), GAP (OFF, exactly 1 cycle).
//  - IDLE: any req -> ON; winner = first set req scanning last_owner+1, +2, ... mod N.
//    Latency: req seen at edge k -> grant/busy/owner valid after edge k (1 cycle).
//  - ON -> GAP at next edge if: done[owner]=1, or req[owner]=0, or timeout (see CONFIGURATION).
//    Otherwise stay ON, same owner. done/req of non-owners ignored while ON.
//  - GAP: grant=0, busy=0, owner=0 for exactly one cycle; arbitration performed during GAP:
//    any req -> ON with new winner; none -> IDLE.
//  - last_owner updated on every entry to ON; hold_cnt cleared on entry to ON.
//  - Simultaneous done[owner] and timeout: one GAP, expired=0 (done takes priority).
//  - Releasing owner still requesting in GAP is a normal candidate; wins again only if no other req.
//  - grant is always one-hot or zero; busy == |grant; owner consistent with grant.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined: hold_cnt counts grant cycles 0..MAX_HOLD-1; ON with
//    hold_cnt==MAX_HOLD-1 and no release -> GAP at next edge, expired=1 during that GAP cycle.
//    Owner gets at most MAX_HOLD consecutive grant cycles.
//  - ARB_TIMEOUT_EN undefined: no hold counter, ownership unbounded, expired tied to 0.
// TESTING
//  - Reset, req=0001 -> next cycle grant=0001, busy=1, owner=0; done[0] pulse -> GAP cycle grant=0 -> IDLE.
//  - After reset, req=0110 held -> grant=0010; done[1] -> 1 GAP cycle -> grant=0100, owner=2.
//  - ARB_TIMEOUT_EN, MAX_HOLD=8, req=1111 held -> grants 0,1,2,3,0 each exactly 8 cycles,
//    1 zero cycle between, expired=1 in each gap.
//  - Owner 2 granted, req[2] drops -> grant=0 after next edge; done[0]=1 while owner=2 -> no effect.
//  - reset asserted while owner=1 -> all outputs 0 after that edge; then req=1000 -> grant=1000, owner=3.
//  - Without ARB_TIMEOUT_EN, req=0001 held 100 cycles -> grant=0001 throughout, expired=0.

Source files
------------

// File: rtl/onoff_rr_arbiter_if.sv
// Requester-side bundle of the ON/OFF round-robin arbiter.
// master = requester pool (drives req/done), slave = arbiter (drives grant/busy/owner/expired).
interface onoff_rr_arbiter_if #(
   parameter int N = 4
);
   localparam int IDW = $clog2(N);

   logic [N-1:0]   req;
   logic [N-1:0]   done;
   logic [N-1:0]   grant;
   logic           busy;
   logic [IDW-1:0] owner;
   logic           expired;

   modport master (
      output req, done,
      input  grant, busy, owner, expired
   );

   modport slave (
      input  req, done,
      output grant, busy, owner, expired
   );
endinterface

// File: rtl/onoff_rr_arbiter.sv
// Round-robin owner of a single ON/OFF resource, 1-cycle OFF gap between owners; optional hold timeout via ARB_TIMEOUT_EN.
// Grant is registered (req at edge k -> grant after edge k); requesters wait on req level, no other backpressure.
module onoff_rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             reset,
   onoff_rr_arbiter_if.slave bus
);
   localparam int IDW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   grant_q, grant_d;
   logic           busy_q, busy_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [IDW-1:0] last_owner_q, last_owner_d;

   logic           found;
   logic [IDW-1:0] win_idx;
   int             scan_idx;
   logic           release_own;
   logic           timeout_hit;
   logic           enter_on;
   logic           stay_on;

   // Scan starts just past the previous owner so every requester gets its turn.
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      scan_idx = 0;
      for (int k = 1; k <= N; k++) begin
         scan_idx = (int'(last_owner_q) + k) % N;
         if (!found && bus.req[scan_idx]) begin
            found   = 1'b1;
            win_idx = IDW'(scan_idx);
         end
      end
   end

   assign release_own = bus.done[owner_q] | ~bus.req[owner_q] | timeout_hit;

   always_comb begin
      state_d      = state_q;
      grant_d      = '0;
      owner_d      = '0;
      last_owner_d = last_owner_q;
      enter_on     = 1'b0;
      stay_on      = 1'b0;
      case (state_q)
         S_IDLE, S_GAP: begin
            if (found) begin
               state_d      = S_ON;
               grant_d      = N'(1) << win_idx;
               owner_d      = win_idx;
               last_owner_d = win_idx;
               enter_on     = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ON: begin
            if (release_own) begin
               state_d = S_GAP;
            end else begin
               grant_d = grant_q;
               owner_d = owner_q;
               stay_on = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = |grant_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         owner_q      <= '0;
         last_owner_q <= IDW'(N - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
   logic           expired_q, expired_d;

   assign timeout_hit = (hold_cnt_q == HCW'(MAX_HOLD - 1));

   // An explicit release (done or dropped req) in the last cycle wins over the timeout.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      expired_d  = 1'b0;
      if (enter_on) begin
         hold_cnt_d = '0;
      end else if (stay_on) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
      end
      if (state_q == S_ON && timeout_hit && !bus.done[owner_q] && bus.req[owner_q]) begin
         expired_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt_q <= '0;
         expired_q  <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         expired_q  <= expired_d;
      end
   end

   assign bus.expired = expired_q;
`else
   // Ownership is unbounded; this is never true for a legal MAX_HOLD.
   assign timeout_hit = (MAX_HOLD < 1);
   assign bus.expired = 1'b0;
`endif

   assign bus.grant = grant_q;
   assign bus.busy  = busy_q;
   assign bus.owner = owner_q;
endmodule
